// File: rtl/seg_scan_mux.sv
// seg_scan_mux
// Purpose: time-multiplexes five active-low 7-segment patterns onto one shared
// segment bus for a common-anode 5-digit display. All digit patterns and the
// brightness level are latched together at the start of each frame, so a
// displayed frame never mixes old and new data. Each digit slot opens with a
// short all-off window that suppresses ghosting, and 16-level PWM sets the
// brightness during the rest of the slot.
//
// Ports:
//   i_Clk         system clock (shared with the CPU)
//   i_Rst         synchronous active-high reset
//   i_Enable      scan enable; low blanks the display and parks the scan at frame start
//   i_Seg_first   active-low segment pattern, digit 0
//   i_Seg_second  active-low segment pattern, digit 1
//   i_Seg_third   active-low segment pattern, digit 2
//   i_Seg_fourth  active-low segment pattern, digit 3
//   i_Seg_fifth   active-low segment pattern, digit 4
//   i_Brightness  PWM duty level, 0 = off, 15 = fully on
//   o_Seg         shared active-low segment bus (registered)
//   o_Digit_n     active-low anode enables, bit k = digit k (registered)
//   o_Frame_done  one-cycle pulse on the first cycle of each new frame
`timescale 1ns/1ps

module seg_scan_mux #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  input  logic [6:0] i_Seg_first,
  input  logic [6:0] i_Seg_second,
  input  logic [6:0] i_Seg_third,
  input  logic [6:0] i_Seg_fourth,
  input  logic [6:0] i_Seg_fifth,
  input  logic [3:0] i_Brightness,
  output logic [6:0] o_Seg,
  output logic [4:0] o_Digit_n,
  output logic       o_Frame_done
);

  localparam int SLOT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [4:0] ANODE_OFF = 5'h1F;

  logic [SLOT_W-1:0] slot_cnt;
  logic [2:0]        idx;
  logic [3:0]        pwm_cnt;
  logic [6:0]        shadow [5];
  logic [3:0]        bright_sh;

  logic              slot_wrap;
  logic              frame_start;
  logic              active;
  logic              lit;
  logic [6:0]        cur_seg;
  logic [4:0]        cur_anode;

  assign slot_wrap   = (slot_cnt == SLOT_LAST);
  assign frame_start = (slot_cnt == '0) && (idx == 3'd0);
  assign active      = (slot_cnt >= BLANK_END);

  // Level 15 is forced fully on; otherwise the 4-bit PWM phase gives
  // bright_sh lit cycles out of every 16.
  assign lit = active && ((bright_sh == 4'hF) || (pwm_cnt < bright_sh));

  // Pattern and anode for the digit owning the current slot.
  always_comb begin
    cur_seg   = SEG_OFF;
    cur_anode = ANODE_OFF;
    case (idx)
      3'd0: begin cur_seg = shadow[0]; cur_anode = 5'b11110; end
      3'd1: begin cur_seg = shadow[1]; cur_anode = 5'b11101; end
      3'd2: begin cur_seg = shadow[2]; cur_anode = 5'b11011; end
      3'd3: begin cur_seg = shadow[3]; cur_anode = 5'b10111; end
      3'd4: begin cur_seg = shadow[4]; cur_anode = 5'b01111; end
      default: begin cur_seg = SEG_OFF; cur_anode = ANODE_OFF; end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      slot_cnt     <= '0;
      idx          <= 3'd0;
      pwm_cnt      <= 4'd0;
      for (int k = 0; k < 5; k++) shadow[k] <= SEG_OFF;
      bright_sh    <= 4'hF;
      o_Seg        <= SEG_OFF;
      o_Digit_n    <= ANODE_OFF;
      o_Frame_done <= 1'b0;
    end else if (!i_Enable) begin
      // Parking at slot 0 / digit 0 makes the first re-enabled cycle a frame start.
      slot_cnt     <= '0;
      idx          <= 3'd0;
      pwm_cnt      <= 4'd0;
      o_Seg        <= SEG_OFF;
      o_Digit_n    <= ANODE_OFF;
      o_Frame_done <= 1'b0;
    end else begin
      if (frame_start) begin
        shadow[0] <= i_Seg_first;
        shadow[1] <= i_Seg_second;
        shadow[2] <= i_Seg_third;
        shadow[3] <= i_Seg_fourth;
        shadow[4] <= i_Seg_fifth;
        bright_sh <= i_Brightness;
      end

      if (slot_wrap) begin
        slot_cnt <= '0;
        idx      <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      end else begin
        slot_cnt <= slot_cnt + SLOT_ONE;
      end

      // Held at zero through the blank window so every slot starts its PWM
      // pattern at phase 0 on the first active cycle.
      pwm_cnt <= active ? pwm_cnt + 4'd1 : 4'd0;

      // Only a real 4->0 wrap pulses, never the parked start after reset or enable.
      o_Frame_done <= slot_wrap && (idx == 3'd4);

      if (lit) begin
        o_Seg     <= cur_seg;
        o_Digit_n <= cur_anode;
      end else begin
        o_Seg     <= SEG_OFF;
        o_Digit_n <= ANODE_OFF;
      end
    end
  end

endmodule
